// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state encoding and
// the saturating helper used by the optional grant counters.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins outright; on a tie the
// requester that was not granted last time wins.
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    if (&req) grant = ~last_grant;
    else      grant = req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one MemoryController port between two req/ack requesters, one
// transaction in flight. Define MEM_ARB_PERF_EN to add per-requester grant counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_SIZE   = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r0_req,
  input  logic                 r0_we,
  input  logic [31:0]          r0_addr,
  input  logic [MEM_WIDTH-1:0] r0_wdata,
  output logic                 r0_ack,
  output logic [MEM_WIDTH-1:0] r0_rdata,
  input  logic                 r1_req,
  input  logic                 r1_we,
  input  logic [31:0]          r1_addr,
  input  logic [MEM_WIDTH-1:0] r1_wdata,
  output logic                 r1_ack,
  output logic [MEM_WIDTH-1:0] r1_rdata,
  output logic [31:0]          mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  input  logic [MEM_WIDTH-1:0] mem_read_val
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]          r0_grant_cnt,
  output logic [15:0]          r1_grant_cnt
`endif
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  arb_state_e                state;
  logic [1:0]                req;
  logic                      grant, grant_vld;
  logic                      last_grant, owner, we_q;
  logic [LW-1:0]             lat_cnt;
  logic [1:0]                ack_q;
  logic [1:0][MEM_WIDTH-1:0] rdata_q;
  logic                      sel_we;
  logic [AW-1:0]             sel_addr;
  logic [MEM_WIDTH-1:0]      sel_wdata;
  logic                      addr_unused;

  assign req       = {r1_req, r0_req};
  assign sel_we    = grant ? r1_we : r0_we;
  assign sel_addr  = grant ? r1_addr[AW-1:0] : r0_addr[AW-1:0];
  assign sel_wdata = grant ? r1_wdata : r0_wdata;
  // Out-of-range addresses wrap silently, so the upper bits are dropped.
  assign addr_unused = ^{r0_addr[31:AW], r1_addr[31:AW]};

  mem_arb_rr u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_vld)
  );

  // mem_* outputs are loaded on the IDLE->ISSUE edge so they are live only in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      we_q          <= 1'b0;
      lat_cnt       <= '0;
      ack_q         <= '0;
      rdata_q       <= '0;
      mem_addr      <= '0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_write_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner         <= grant;
            last_grant    <= grant;
            we_q          <= sel_we;
            mem_addr      <= {{(32-AW){1'b0}}, sel_addr};
            mem_write_val <= sel_wdata;
            mem_write_en  <= sel_we;
            mem_read_en   <= ~sel_we;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          mem_addr      <= '0;
          mem_read_en   <= 1'b0;
          mem_write_en  <= 1'b0;
          mem_write_val <= '0;
          if (we_q) begin
            ack_q[owner] <= 1'b1;
            state        <= DONE;
          end else begin
            lat_cnt <= LW'(RD_LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          // Final WAIT cycle is exactly RD_LATENCY cycles after the strobe.
          if (lat_cnt == '0) begin
            rdata_q[owner] <= mem_read_val;
            ack_q[owner]   <= 1'b1;
            state          <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: begin
          ack_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r0_ack   = ack_q[0];
  assign r1_ack   = ack_q[1];
  assign r0_rdata = rdata_q[0];
  assign r1_rdata = rdata_q[1];

`ifdef MEM_ARB_PERF_EN
  logic [1:0][CNT_W-1:0] grant_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         grant_cnt        <= '0;
    else if (state == IDLE && grant_vld) grant_cnt[grant] <= sat_inc(grant_cnt[grant]);
  end

  assign r0_grant_cnt = grant_cnt[0];
  assign r1_grant_cnt = grant_cnt[1];
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner-case sequences and a
// randomized run against a transaction-level model. Two DUTs: RD_LATENCY 1 and 3.
module tb_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        ack   [2][2];
  logic [31:0] rdata [2][2];
  logic [31:0] mem_addr [2];
  logic        mem_re   [2];
  logic        mem_we   [2];
  logic [31:0] mem_wv   [2];
  logic [31:0] mem_rv   [2];
`ifdef MEM_ARB_PERF_EN
  logic [15:0] gcnt [2][2];
`endif

  // Memory controller model: read data appears exactly L cycles after the
  // strobe; every other cycle carries random junk.
  for (genvar d = 0; d < 2; d++) begin : g_mem
    localparam int L = (d == 0) ? 1 : 3;
    logic [31:0] mem  [256];
    logic [31:0] pipe [L];

    initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;

    always @(posedge clk) begin
      if (mem_we[d]) mem[mem_addr[d][7:0]] = mem_wv[d];
      pipe[0] <= mem_re[d] ? mem[mem_addr[d][7:0]] : ($urandom | 32'h8000_0000);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rv[d] = pipe[L-1];

    mem_arbiter #(.MEM_WIDTH(32), .MEM_SIZE(256), .RD_LATENCY(L)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .r0_req        (req[d][0]),
      .r0_we         (we[d][0]),
      .r0_addr       (addr[d][0]),
      .r0_wdata      (wdata[d][0]),
      .r0_ack        (ack[d][0]),
      .r0_rdata      (rdata[d][0]),
      .r1_req        (req[d][1]),
      .r1_we         (we[d][1]),
      .r1_addr       (addr[d][1]),
      .r1_wdata      (wdata[d][1]),
      .r1_ack        (ack[d][1]),
      .r1_rdata      (rdata[d][1]),
      .mem_addr      (mem_addr[d]),
      .mem_read_en   (mem_re[d]),
      .mem_write_en  (mem_we[d]),
      .mem_write_val (mem_wv[d]),
      .mem_read_val  (mem_rv[d])
`ifdef MEM_ARB_PERF_EN
      ,
      .r0_grant_cnt  (gcnt[d][0]),
      .r1_grant_cnt  (gcnt[d][1])
`endif
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          who;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_maddr;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic [31:0] maddr;
    int          nrs;
    int          nws;
    bit          other;
    bit          stuck;
  } res_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2; i++) begin
        req[d][i]   = 1'b0;
        we[d][i]    = 1'b0;
        addr[d][i]  = '0;
        wdata[d][i] = '0;
      end
  endtask

  task automatic do_reset();
    idle_all();
    #2 rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Latency is counted inclusively: request cycle through ack cycle.
  task automatic run_txn(input int d, input int who, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, output res_t r);
    r = '{default: 0};
    we[d][who]    = w;
    addr[d][who]  = a;
    wdata[d][who] = wd;
    req[d][who]   = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (mem_re[d]) begin r.nrs++; r.maddr = mem_addr[d]; end
      if (mem_we[d]) begin r.nws++; r.maddr = mem_addr[d]; end
      if (ack[d][1-who]) r.other = 1'b1;
      if (ack[d][who]) begin
        r.lat = k + 1;
        r.rd  = rdata[d][who];
        req[d][who] = 1'b0;
        break;
      end
    end
    req[d][who] = 1'b0;
    if (r.lat > 0) begin
      step();
      r.stuck = ack[d][who];
    end
  endtask

  vec_t tbl [8];
  res_t r;
  int   order [$];
  bit   overlap, seen;
  int   who;

  initial begin
    tbl[0] = '{0, 1'b1, 32'h003, 32'h11,        32'h0,         32'h03, 3};
    tbl[1] = '{1, 1'b0, 32'h003, 32'h0,         32'h11,        32'h03, 4};
    tbl[2] = '{0, 1'b1, 32'h105, 32'hA5A5,      32'h0,         32'h05, 3};
    tbl[3] = '{1, 1'b0, 32'h005, 32'h0,         32'hA5A5,      32'h05, 4};
    tbl[4] = '{0, 1'b0, 32'h0FF, 32'h0,         32'hC0DE_00FF, 32'hFF, 4};
    tbl[5] = '{1, 1'b1, 32'h1FF, 32'h77,        32'hA5A5,      32'hFF, 3};
    tbl[6] = '{0, 1'b0, 32'h2FF, 32'h0,         32'h77,        32'hFF, 4};
    tbl[7] = '{0, 1'b1, 32'h010, 32'hDEADBEEF,  32'h77,        32'h10, 3};

    // Reset state, sampled while rst_n is still low.
    idle_all();
    repeat (2) step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack0",  ack[d][0],   0);
      chk("rst_ack1",  ack[d][1],   0);
      chk("rst_rd0",   rdata[d][0], 0);
      chk("rst_rd1",   rdata[d][1], 0);
      chk("rst_re",    mem_re[d],   0);
      chk("rst_we",    mem_we[d],   0);
      chk("rst_maddr", mem_addr[d], 0);
      chk("rst_wval",  mem_wv[d],   0);
    end
    rst_n = 1'b1;
    step();

    // Directed single-requester transactions, including address wrap.
    for (int v = 0; v < 8; v++) begin
      run_txn(0, tbl[v].who, tbl[v].we, tbl[v].addr, tbl[v].wdata, r);
      chk($sformatf("tbl%0d_lat", v),   r.lat,   tbl[v].exp_lat);
      chk($sformatf("tbl%0d_rdata", v), r.rd,    tbl[v].exp_rdata);
      chk($sformatf("tbl%0d_maddr", v), r.maddr, tbl[v].exp_maddr);
      chk($sformatf("tbl%0d_nread", v), r.nrs,   tbl[v].we ? 0 : 1);
      chk($sformatf("tbl%0d_nwrite", v), r.nws,  tbl[v].we ? 1 : 0);
      chk($sformatf("tbl%0d_other", v), r.other, 0);
      chk($sformatf("tbl%0d_pulse", v), r.stuck, 0);
    end

    // Both requesting from reset: grants alternate starting with r0.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      we[0][i] = 1'b1; addr[0][i] = 32'h20 + i; wdata[0][i] = 32'h100 + i; req[0][i] = 1'b1;
    end
    overlap = 1'b0;
    order.delete();
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      step();
      if (ack[0][0] && ack[0][1]) overlap = 1'b1;
      if (ack[0][0]) order.push_back(0);
      if (ack[0][1]) order.push_back(1);
      if (order.size() >= 4) begin req[0][0] = 1'b0; req[0][1] = 1'b0; end
    end
    idle_all();
    chk("t3_count", order.size(), 4);
    for (int j = 0; j < 4; j++) chk($sformatf("t3_order%0d", j), (order.size() > j) ? order[j] : -1, j % 2);
    chk("t3_overlap", overlap, 0);
    repeat (6) begin step(); chk("t3_quiet", ack[0][0] | ack[0][1], 0); end

    // Reset during the WAIT of an r0 read: no ack, outputs cleared, r0 wins afterwards.
    do_reset();
    run_txn(0, 0, 1'b0, 32'h10, 32'h0, r);
    chk("t4_pre_rd", r.rd, 32'hDEADBEEF);
    we[0][0] = 1'b0; addr[0][0] = 32'h3; req[0][0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin step(); seen = mem_re[0]; end
    chk("t4_issue", seen, 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_ack",   ack[0][0],   0);
    chk("t4_re",    mem_re[0],   0);
    chk("t4_we",    mem_we[0],   0);
    chk("t4_maddr", mem_addr[0], 0);
    chk("t4_rdata", rdata[0][0], 0);
    we[0][1] = 1'b1; addr[0][1] = 32'h9; wdata[0][1] = 32'h5; req[0][1] = 1'b1;
    repeat (2) begin step(); chk("t4_noack", ack[0][0], 0); end
    rst_n = 1'b1;
    who = -1;
    for (int k = 0; k < 12 && who < 0; k++) begin
      step();
      if (ack[0][0]) who = 0;
      else if (ack[0][1]) who = 1;
    end
    chk("t4_first", who, 0);
    chk("t4_rd", rdata[0][0], 32'h11);
    req[0][0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin step(); seen = ack[0][1]; end
    chk("t4_r1_done", seen, 1);
    idle_all();
    step();

    // RD_LATENCY = 3 instance: write then read back.
    run_txn(1, 0, 1'b1, 32'h7, 32'h8, r);
    chk("t5_wlat", r.lat, 3);
    chk("t5_nws",  r.nws, 1);
    run_txn(1, 0, 1'b0, 32'h7, 32'h0, r);
    chk("t5_rlat",  r.lat,   6);
    chk("t5_rdata", r.rd,    32'h8);
    chk("t5_maddr", r.maddr, 32'h7);

    // Grant counters.
    do_reset();
`ifdef MEM_ARB_PERF_EN
    chk("t6_rst0", gcnt[0][0], 0);
    chk("t6_rst1", gcnt[0][1], 0);
`endif
    for (int j = 0; j < 5; j++) run_txn(0, 0, 1'b1, 32'h40 + j, j, r);
    for (int j = 0; j < 2; j++) run_txn(0, 1, 1'b1, 32'h48 + j, j, r);
`ifdef MEM_ARB_PERF_EN
    chk("t6_cnt0",  gcnt[0][0], 5);
    chk("t6_cnt1",  gcnt[0][1], 2);
    chk("t6_other", gcnt[1][0], 0);
`endif

    // Randomized traffic against a transaction-level model.
    begin
      logic [31:0] mref [256];
      logic [31:0] exp_rd [2];
      logic [31:0] txn_rd;
      bit          outst [2];
      bit          txn_we, e;
      int          owner, ack_at, free_from, last, g;

      do_reset();
      for (int i = 0; i < 256; i++) mref[i] = g_mem[0].mem[i];
      owner = -1; ack_at = -1; free_from = 0; last = 1; txn_rd = '0; txn_we = 1'b0;
      for (int i = 0; i < 2; i++) begin outst[i] = 1'b0; exp_rd[i] = '0; end

      for (int n = 0; n < 1500; n++) begin
        step();
        for (int i = 0; i < 2; i++) begin
          e = (owner == i) && (n == ack_at);
          if (e && !txn_we) exp_rd[i] = txn_rd;
          chk($sformatf("rnd_ack%0d", i),   ack[0][i],   e);
          chk($sformatf("rnd_rdata%0d", i), rdata[0][i], exp_rd[i]);
        end
        chk("rnd_en_excl", mem_re[0] & mem_we[0], 0);

        if (owner >= 0 && n == ack_at) begin
          outst[owner] = 1'b0; req[0][owner] = 1'b0; owner = -1;
        end
        if (owner >= 0 && req[0][owner] && $urandom_range(7) == 0) req[0][owner] = 1'b0;
        for (int i = 0; i < 2; i++)
          if (!outst[i] && $urandom_range(2) == 0) begin
            outst[i] = 1'b1; req[0][i] = 1'b1; we[0][i] = $urandom_range(1) == 1;
            addr[0][i] = $urandom_range(511); wdata[0][i] = $urandom;
          end

        if (owner < 0 && n >= free_from && (req[0][0] || req[0][1])) begin
          if (req[0][0] && req[0][1]) g = 1 - last;
          else                        g = req[0][1] ? 1 : 0;
          owner = g; last = g; txn_we = we[0][g];
          ack_at = n + 2 + (txn_we ? 0 : 1);
          free_from = ack_at + 1;
          if (txn_we) mref[addr[0][g][7:0]] = wdata[0][g];
          else        txn_rd = mref[addr[0][g][7:0]];
        end
      end
      idle_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
